// File: rtl/lfsr_rr_scheduler_if.sv
// Request/grant bundle between the LFSR scheduler and its consumers.
// Handshake: req is a level held until its gnt pulse. gnt with rnd_vld is a one-cycle valid
// with no ready, so the consumer must take rnd in the cycle its gnt bit is high.
interface lfsr_rr_scheduler_if #(
    parameter int W    = 3,
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic            seed_load;
    logic [W-1:0]    seed;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    rnd;
    logic            rnd_vld;
    logic            busy;
    logic            seed_zero_err;
    logic [1:0]      state_dbg;

    modport master (
        output req, seed_load, seed,
        input  gnt, rnd, rnd_vld, busy, seed_zero_err, state_dbg
    );

    modport slave (
        input  req, seed_load, seed,
        output gnt, rnd, rnd_vld, busy, seed_zero_err, state_dbg
    );
endinterface

// File: rtl/lfsr_rr_scheduler.sv
// Round-robin sharing of one Galois LFSR between NREQ requesters, with seed load,
// zero-seed substitution and a post-seed warm-up run.
module lfsr_rr_scheduler #(
    parameter int           W            = 3,
    parameter logic [W-1:0] TAPS         = 3'b100,
    parameter logic [W-1:0] SEED_DEFAULT = 1,
    parameter int           NREQ         = 4,
    parameter int           WARMUP       = 2
) (
    input logic           clk,
    input logic           arst_n,
    lfsr_rr_scheduler_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic [1:0] {SERVE = 2'd0, LOAD = 2'd1, WARM = 2'd2} state_t;

    state_t          state, state_n;
    logic [W-1:0]    lfsr, lfsr_n;
    logic [PW-1:0]   rr_ptr, rr_ptr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NREQ-1:0] gnt, gnt_n;
    logic [W-1:0]    rnd, rnd_n;
    logic            rnd_vld, rnd_vld_n;
    logic            zerr, zerr_n;

    logic            found;
    logic [PW-1:0]   pick;
    int              idx;
    logic            seed_is_zero;
    logic [W-1:0]    seed_val;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
        logic fb;
        fb = v[W-1];
        return {v[W-2:0], fb} ^ (fb ? TAPS : '0);
    endfunction

    assign seed_is_zero = (bus.seed == '0);
    assign seed_val     = seed_is_zero ? SEED_DEFAULT : bus.seed;

    // First active requester strictly after the last one served, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state;
        lfsr_n    = lfsr;
        rr_ptr_n  = rr_ptr;
        cnt_n     = cnt;
        gnt_n     = '0;
        rnd_n     = rnd;
        rnd_vld_n = 1'b0;
        zerr_n    = 1'b0;
        if (bus.seed_load) begin
            // Seed load wins in every state and restarts the LOAD/WARM sequence.
            state_n = LOAD;
            lfsr_n  = seed_val;
            zerr_n  = seed_is_zero;
        end else begin
            case (state)
                SERVE: begin
                    if (found) begin
                        gnt_n[pick] = 1'b1;
                        rnd_n       = lfsr;
                        rnd_vld_n   = 1'b1;
                        lfsr_n      = lfsr_step(lfsr);
                        rr_ptr_n    = pick;
                    end
                end
                LOAD: begin
                    cnt_n   = '0;
                    state_n = (WARMUP > 0) ? WARM : SERVE;
                end
                WARM: begin
                    lfsr_n = lfsr_step(lfsr);
                    if (int'(cnt) >= WARMUP - 1) state_n = SERVE;
                    else                         cnt_n   = cnt + 1'b1;
                end
                default: state_n = SERVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= SERVE;
            lfsr    <= SEED_DEFAULT;
            rr_ptr  <= PW'(NREQ - 1);
            cnt     <= '0;
            gnt     <= '0;
            rnd     <= '0;
            rnd_vld <= 1'b0;
            zerr    <= 1'b0;
        end else begin
            state   <= state_n;
            lfsr    <= lfsr_n;
            rr_ptr  <= rr_ptr_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            rnd     <= rnd_n;
            rnd_vld <= rnd_vld_n;
            zerr    <= zerr_n;
        end
    end

    assign bus.gnt           = gnt;
    assign bus.rnd           = rnd;
    assign bus.rnd_vld       = rnd_vld;
    assign bus.busy          = (state != SERVE);
    assign bus.seed_zero_err = zerr;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Directed bench for lfsr_rr_scheduler: a cycle-level behavioural model checked every
// negedge, plus literal expectations taken from the hand-worked sequences.
module tb_lfsr_rr_scheduler;
    localparam int W      = 3;
    localparam int NREQ   = 4;
    localparam int WARMUP = 2;
    localparam logic [W-1:0] TAPS = 3'b100;

    logic clk;
    logic arst_n;
    lfsr_rr_scheduler_if #(.W(W), .NREQ(NREQ)) bus ();

    lfsr_rr_scheduler #(
        .W(W), .TAPS(TAPS), .SEED_DEFAULT(3'd1), .NREQ(NREQ), .WARMUP(WARMUP)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // ---------------- model state ----------------
    int              m_lfsr;
    int              m_last;
    int              m_busy_left;   // cycles of LOAD+WARM still to run
    logic [NREQ-1:0] exp_gnt;
    logic [W-1:0]    exp_rnd;
    logic            exp_vld, exp_busy, exp_zerr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Multiply by two modulo 2^W; the bit carried out selects the tap mask.
    function automatic int model_step(input int v);
        int s;
        s = v * 2;
        if (s >= (1 << W)) return (s - (1 << W) + 1) ^ int'(TAPS);
        return s;
    endfunction

    task automatic model_reset();
        m_lfsr      = 1;
        m_last      = NREQ - 1;
        m_busy_left = 0;
        exp_gnt     = '0;
        exp_rnd     = '0;
        exp_vld     = 1'b0;
        exp_busy    = 1'b0;
        exp_zerr    = 1'b0;
    endtask

    // Advance the model with the current inputs, then let the DUT take the edge.
    task automatic cycle();
        logic [NREQ-1:0] n_gnt;
        logic [W-1:0]    n_rnd;
        logic            n_vld, n_zerr;
        n_gnt  = '0;
        n_rnd  = exp_rnd;
        n_vld  = 1'b0;
        n_zerr = 1'b0;
        if (bus.seed_load) begin
            m_lfsr      = (bus.seed == 0) ? 1 : int'(bus.seed);
            n_zerr      = (bus.seed == 0);
            m_busy_left = 1 + WARMUP;
        end else if (m_busy_left > 0) begin
            if (m_busy_left <= WARMUP) m_lfsr = model_step(m_lfsr);
            m_busy_left--;
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                int k;
                k = (m_last + i) % NREQ;
                if (!n_vld && bus.req[k]) begin
                    n_vld    = 1'b1;
                    n_gnt[k] = 1'b1;
                    n_rnd    = W'(m_lfsr);
                    m_lfsr   = model_step(m_lfsr);
                    m_last   = k;
                end
            end
        end
        @(posedge clk);
        #1;
        exp_gnt  = n_gnt;
        exp_rnd  = n_rnd;
        exp_vld  = n_vld;
        exp_zerr = n_zerr;
        exp_busy = (m_busy_left > 0);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt",           int'(bus.gnt),           int'(exp_gnt));
            check("rnd",           int'(bus.rnd),           int'(exp_rnd));
            check("rnd_vld",       int'(bus.rnd_vld),       int'(exp_vld));
            check("busy",          int'(bus.busy),          int'(exp_busy));
            check("seed_zero_err", int'(bus.seed_zero_err), int'(exp_zerr));
        end
    end

    // ---------------- directed stimulus ----------------
    int seq1 [8] = '{1, 2, 4, 5, 7, 3, 6, 1};
    int gnt2 [5] = '{1, 2, 4, 8, 1};
    logic [NREQ-1:0] mix [8] = '{4'b1010, 4'b0110, 4'b0000, 4'b1001,
                                 4'b1111, 4'b0011, 4'b0100, 4'b1111};

    initial begin
        bus.req       = '0;
        bus.seed_load = 1'b0;
        bus.seed      = '0;
        arst_n        = 1'b0;
        model_reset();
        #2;
        chk_en = 1'b1;
        do_reset();
        check("reset_busy", int'(bus.busy), 0);
        check("reset_gnt",  int'(bus.gnt),  0);

        // 1: single requester walks the whole period
        bus.req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("t1_rnd", int'(bus.rnd), seq1[i]);
            check("t1_gnt", int'(bus.gnt), 1);
        end
        bus.req = '0;
        cycle();

        // 2: all requesting, rotation starts at requester 0
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2_gnt", int'(bus.gnt), gnt2[i]);
            check("t2_rnd", int'(bus.rnd), seq1[i]);
        end
        bus.req = '0;
        cycle();

        // 3: seed 5, three busy cycles, first word 3
        do_reset();
        bus.req       = 4'b0001;
        bus.seed_load = 1'b1;
        bus.seed      = 3'd5;
        cycle();
        bus.seed_load = 1'b0;
        check("t3_busy0", int'(bus.busy), 1);
        cycle(); check("t3_busy1", int'(bus.busy), 1);
        cycle(); check("t3_busy2", int'(bus.busy), 1);
        cycle(); check("t3_busy3", int'(bus.busy), 0);
        check("t3_nognt", int'(bus.gnt), 0);
        cycle(); check("t3_rnd", int'(bus.rnd), 3);
        check("t3_gnt", int'(bus.gnt), 1);
        bus.req = '0;
        cycle();

        // 4: zero seed substitutes 1, warm-up gives first word 4
        bus.req       = 4'b0001;
        bus.seed_load = 1'b1;
        bus.seed      = 3'd0;
        cycle();
        bus.seed_load = 1'b0;
        check("t4_zerr", int'(bus.seed_zero_err), 1);
        cycle();
        check("t4_zerr_end", int'(bus.seed_zero_err), 0);
        cycle(); cycle(); cycle();
        check("t4_rnd", int'(bus.rnd), 4);
        bus.req = '0;
        cycle();

        // 5: seed_load beats a simultaneous request; seed 6 -> 6,1,2
        bus.req       = 4'b0100;
        bus.seed_load = 1'b1;
        bus.seed      = 3'd6;
        cycle();
        bus.seed_load = 1'b0;
        check("t5_nognt", int'(bus.gnt), 0);
        cycle(); cycle(); cycle();
        check("t5_nognt_warm", int'(bus.gnt), 0);
        cycle();
        check("t5_gnt", int'(bus.gnt), 4);
        check("t5_rnd", int'(bus.rnd), 2);

        // mixed request patterns, model-checked only
        for (int i = 0; i < 8; i++) begin
            bus.req = mix[i];
            cycle();
        end

        // seed_load during WARM restarts the sequence
        bus.req       = 4'b1000;
        bus.seed_load = 1'b1;
        bus.seed      = 3'd7;
        cycle();
        bus.seed_load = 1'b0;
        cycle(); cycle();
        bus.seed_load = 1'b1;
        bus.seed      = 3'd3;
        cycle();
        bus.seed_load = 1'b0;
        for (int i = 0; i < 5; i++) cycle();

        // 6: asynchronous reset in the middle of WARM
        bus.req       = 4'b0001;
        bus.seed_load = 1'b1;
        bus.seed      = 3'd4;
        cycle();
        bus.seed_load = 1'b0;
        cycle();
        cycle();
        check("t6_in_warm", int'(bus.state_dbg), 2);
        #2;
        arst_n = 1'b0;
        model_reset();
        #1;
        check("t6_busy", int'(bus.busy), 0);
        check("t6_gnt",  int'(bus.gnt),  0);
        check("t6_rnd",  int'(bus.rnd),  0);
        @(negedge clk);
        #1;
        arst_n = 1'b1;
        cycle();
        check("t6_rnd_after", int'(bus.rnd), 1);
        check("t6_gnt_after", int'(bus.gnt), 1);
        bus.req = '0;
        cycle();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
